// File: rtl/adc_sample_packer.sv
// -----------------------------------------------------------------------------
// adc_sample_packer
//
// Packs pairs of 16-bit ADC samples into 32-bit words and streams them out
// over AXI-Stream. The first sample of a pair becomes bits [15:0] and the
// second completes the word as bits [31:16]. Completed words go into a
// 2-entry FIFO that holds {TLAST, TDATA}. TLAST marks every FRAME_WORDS-th
// word that was actually pushed. When the FIFO is full and nothing pops in
// the same cycle, the word is dropped. A drop sets a sticky flag and bumps
// a saturating drop counter.
//
// Parameters
//   FRAME_WORDS      words per frame (2..65535)
//
// Ports
//   Clk_i            rising-edge clock
//   Rstn_i           asynchronous active-low reset
//   Enable_i         capture enable; low returns the packer to IDLE
//   AdcData_i        16-bit sample
//   AdcValid_i       sample strobe, one sample per high cycle
//   M_AXIS_TDATA_o   packed word (FIFO head)
//   M_AXIS_TVALID_o  FIFO not empty
//   M_AXIS_TREADY_i  downstream ready
//   M_AXIS_TLAST_o   frame end marker of the FIFO head
//   Overflow_o       sticky drop flag
//   OverflowClr_i    clears Overflow_o and DroppedCnt_o (wins over a drop)
//   DroppedCnt_o     dropped-word count, saturating at 0xFFFF
//
// Build option
//   ADC_PACKER_TEST_PATTERN_EN  when defined, an internal 16-bit counter
//                               replaces AdcData_i. The counter steps on
//                               every accepted sample.
// -----------------------------------------------------------------------------
module adc_sample_packer #(
  parameter int unsigned FRAME_WORDS = 256
) (
  input  logic        Clk_i,
  input  logic        Rstn_i,
  input  logic        Enable_i,
  input  logic [15:0] AdcData_i,
  input  logic        AdcValid_i,
  output logic [31:0] M_AXIS_TDATA_o,
  output logic        M_AXIS_TVALID_o,
  input  logic        M_AXIS_TREADY_i,
  output logic        M_AXIS_TLAST_o,
  output logic        Overflow_o,
  input  logic        OverflowClr_i,
  output logic [15:0] DroppedCnt_o
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] low_q, low_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [32:0] fifo_mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic [15:0] sample_data;
  logic        sample_fire;
  logic        word_done;
  logic        word_last;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        drop;

  // A sample counts only while enabled and out of IDLE. A low Enable_i
  // overrides any strobe in the same cycle.
  assign sample_fire = AdcValid_i && Enable_i && (state_q != S_IDLE);

`ifdef ADC_PACKER_TEST_PATTERN_EN
  logic [15:0] tp_cnt_q;

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      tp_cnt_q <= '0;
    end else if (sample_fire) begin
      tp_cnt_q <= tp_cnt_q + 16'd1;
    end
  end

  assign sample_data = tp_cnt_q;
`else
  assign sample_data = AdcData_i;
`endif

  assign word_done = sample_fire && (state_q == S_HIGH);
  assign word_last = (word_cnt_q == LAST_IDX);
  assign fifo_full = (count_q == 2'd2);
  assign pop       = (count_q != 2'd0) && M_AXIS_TREADY_i;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push      = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Next-state logic: packing FSM, frame counter, overflow bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    low_d      = low_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_LOW;
      end
      S_LOW: begin
        if (sample_fire) begin
          low_d   = sample_data;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (sample_fire) begin
          state_d = S_LOW;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Going to IDLE throws away any pending half-word. The half-word is
    // lost because only S_HIGH completes a word. Going to IDLE also restarts
    // the frame. Words already queued keep the TLAST they were stored with.
    if (!Enable_i) begin
      state_d    = S_IDLE;
      word_cnt_d = '0;
    end else if (push) begin
      word_cnt_d = word_last ? 16'd0 : word_cnt_q + 16'd1;
    end

    if (OverflowClr_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever the order of the processes.
    if (!Rstn_i) begin
      state_q    <= S_IDLE;
      low_q      <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      // NOTE: the storage is reset on purpose. The head entry drives
      // TDATA/TLAST directly, and those outputs must read zero in reset.
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      // When full, a push that comes with a pop writes into the slot being
      // vacated. wr_ptr equals rd_ptr in that case.
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {word_last, sample_data, low_q};
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign M_AXIS_TVALID_o = (count_q != 2'd0);
  assign M_AXIS_TDATA_o  = fifo_mem_q[rd_ptr_q][31:0];
  assign M_AXIS_TLAST_o  = fifo_mem_q[rd_ptr_q][32];
  assign Overflow_o      = ovf_q;
  assign DroppedCnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_packer
//
// Directed bench for adc_sample_packer with FRAME_WORDS = 4.
// A queue-based reference model follows the packer's behaviour at each
// rising edge. A compare process checks the DUT against that model at every
// falling edge. Literal expectations on the logged output stream pin the
// model to known results.
// -----------------------------------------------------------------------------
module tb_adc_sample_packer;

  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic        clr;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        ovf;
  logic [15:0] dcnt;

  int checks   = 0;
  int failures = 0;

  adc_sample_packer #(.FRAME_WORDS(FW)) dut (
    .Clk_i          (clk),
    .Rstn_i         (rst_n),
    .Enable_i       (en),
    .AdcData_i      (data),
    .AdcValid_i     (valid),
    .M_AXIS_TDATA_o (tdata),
    .M_AXIS_TVALID_o(tvalid),
    .M_AXIS_TREADY_i(ready),
    .M_AXIS_TLAST_o (tlast),
    .Overflow_o     (ovf),
    .OverflowClr_i  (clr),
    .DroppedCnt_o   (dcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: words waiting downstream, pending half-word, frame
  // position and drop bookkeeping.
  // ---------------------------------------------------------------------------
  logic [32:0] mq[$];
  bit          m_active;
  bit          m_have_low;
  logic [15:0] m_low;
  logic [15:0] m_tp;
  int          m_frame;
  bit          m_ovf;
  int          m_drop;
  bit          m_dropped;
  bit          m_last;
  logic [15:0] m_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active   = 0;
      m_have_low = 0;
      m_low      = '0;
      m_tp       = '0;
      m_frame    = 0;
      m_ovf      = 0;
      m_drop     = 0;
    end else begin
      m_dropped = 0;
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (!en) begin
        m_active   = 0;
        m_have_low = 0;
        m_frame    = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else if (valid) begin
`ifdef ADC_PACKER_TEST_PATTERN_EN
        m_s  = m_tp;
        m_tp = m_tp + 16'd1;
`else
        m_s = data;
`endif
        if (!m_have_low) begin
          m_low      = m_s;
          m_have_low = 1;
        end else begin
          m_have_low = 0;
          if (mq.size() < 2) begin
            m_last  = (m_frame + 1 == FW);
            m_frame = m_last ? 0 : m_frame + 1;
            mq.push_back({m_last, m_s, m_low});
          end else begin
            m_dropped = 1;
          end
        end
      end
      if (clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end else if (m_dropped) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  end

  // Compare process: the DUT must match the model on every falling edge
  // out of reset.
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("cmp_tvalid", 32'(tvalid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("cmp_tdata", tdata, mq[0][31:0]);
        check("cmp_tlast", 32'(tlast), 32'(mq[0][32]));
      end
      check("cmp_overflow", 32'(ovf), 32'(m_ovf));
      check("cmp_dropped", 32'(dcnt), 32'(m_drop));
    end
  end

  // Log of words that actually left the DUT.
  logic [32:0] log_q[$];

  always @(posedge clk) begin
    if (rst_n && tvalid && ready) log_q.push_back({tlast, tdata});
  end

  task automatic drive(input bit e, input bit v, input logic [15:0] d, input bit r, input bit c);
    en    = e;
    valid = v;
    data  = d;
    ready = r;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp_data,
                           input bit exp_last);
    if (log_q.size() <= idx) begin
      checks++;
      failures++;
      $display("FAIL %s: only %0d words emitted, word %0d required", name, log_q.size(), idx);
    end else begin
`ifndef ADC_PACKER_TEST_PATTERN_EN
      check({name, "_data"}, log_q[idx][31:0], exp_data);
`endif
      check({name, "_last"}, 32'(log_q[idx][32]), 32'(exp_last));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    valid = 1'b0;
    data  = '0;
    ready = 1'b0;
    clr   = 1'b0;

    // Reset values
    #12;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_dropped", 32'(dcnt), 32'd0);
    #6 rst_n = 1'b1;
    cmp_en = 1;
    @(posedge clk);
    #1;

`ifdef ADC_PACKER_TEST_PATTERN_EN
    // The internal counter replaces the sample input.
    log_q.delete();
    drive(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 16'hFFFF, 1, 0);
    repeat (3) drive(1, 0, 16'h0, 1, 0);
    check("tp_count", log_q.size(), 32'd2);
    if (log_q.size() >= 2) begin
      check("tp_word0", log_q[0][31:0], 32'h0001_0000);
      check("tp_word1", log_q[1][31:0], 32'h0003_0002);
    end
    drive(0, 0, 16'h0, 1, 0);
`endif

    // Basic packing, one frame, TREADY held high
    log_q.delete();
    drive(1, 0, 16'h0, 1, 0);
    for (int i = 1; i <= 8; i++) drive(1, 1, 16'(i), 1, 0);
    repeat (3) drive(1, 0, 16'h0, 1, 0);
    check("frame_count", log_q.size(), 32'd4);
    check_log("frame_w0", 0, 32'h0002_0001, 0);
    check_log("frame_w1", 1, 32'h0004_0003, 0);
    check_log("frame_w2", 2, 32'h0006_0005, 0);
    check_log("frame_w3", 3, 32'h0008_0007, 1);

    // Back-pressure: 2 words held, 2 dropped
    log_q.delete();
    for (int i = 1; i <= 8; i++) drive(1, 1, 16'(i), 0, 0);
    check("bp_tvalid", 32'(tvalid), 32'd1);
    check("bp_overflow", 32'(ovf), 32'd1);
    check("bp_dropped", 32'(dcnt), 32'd2);
    repeat (4) drive(1, 0, 16'h0, 1, 0);
    check("bp_count", log_q.size(), 32'd2);
    check_log("bp_w0", 0, 32'h0002_0001, 0);
    check_log("bp_w1", 1, 32'h0004_0003, 0);
    drive(1, 0, 16'h0, 1, 1);
    check("clr_overflow", 32'(ovf), 32'd0);
    check("clr_dropped", 32'(dcnt), 32'd0);

    // Full FIFO: a word that completes while the head pops is kept
    log_q.delete();
    for (int i = 1; i <= 4; i++) drive(1, 1, 16'(16'h10 + i), 0, 0);
    drive(1, 1, 16'h15, 0, 0);
    drive(1, 1, 16'h16, 1, 0);
    check("simul_overflow", 32'(ovf), 32'd0);
    check("simul_dropped", 32'(dcnt), 32'd0);
    repeat (4) drive(1, 0, 16'h0, 1, 0);
    check("simul_count", log_q.size(), 32'd3);
    check_log("simul_w0", 0, 32'h0012_0011, 0);
    check_log("simul_w1", 1, 32'h0014_0013, 1);
    check_log("simul_w2", 2, 32'h0016_0015, 0);

    // A clear in the same cycle as a drop wins over the drop
    for (int i = 1; i <= 4; i++) drive(1, 1, 16'(16'h20 + i), 0, 0);
    drive(1, 1, 16'h25, 0, 0);
    drive(1, 1, 16'h26, 0, 0);
    check("drop_overflow", 32'(ovf), 32'd1);
    check("drop_dropped", 32'(dcnt), 32'd1);
    drive(1, 1, 16'h27, 0, 0);
    drive(1, 1, 16'h28, 0, 1);
    check("prio_overflow", 32'(ovf), 32'd0);
    check("prio_dropped", 32'(dcnt), 32'd0);
    repeat (4) drive(1, 0, 16'h0, 1, 0);

    // Disable after a lone half-word; the frame restarts on re-enable
    drive(0, 0, 16'h0, 1, 0);
    drive(1, 1, 16'hDEAD, 1, 0);
    drive(1, 1, 16'h1234, 1, 0);
    drive(0, 0, 16'h0, 1, 0);
    drive(1, 0, 16'h0, 1, 0);
    log_q.delete();
    drive(1, 1, 16'hAAAA, 1, 0);
    drive(1, 1, 16'hBBBB, 1, 0);
    for (int i = 1; i <= 6; i++) drive(1, 1, 16'(i), 1, 0);
    repeat (3) drive(1, 0, 16'h0, 1, 0);
    check("reen_count", log_q.size(), 32'd4);
    check_log("reen_w0", 0, 32'hBBBB_AAAA, 0);
    check_log("reen_w1", 1, 32'h0002_0001, 0);
    check_log("reen_w2", 2, 32'h0004_0003, 0);
    check_log("reen_w3", 3, 32'h0006_0005, 1);

    // Asynchronous reset mid-frame with one word buffered and a half pending
    drive(1, 1, 16'h0001, 0, 0);
    drive(1, 1, 16'h0002, 0, 0);
    drive(1, 1, 16'h0003, 0, 0);
    check("pre_rst_tvalid", 32'(tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(tvalid), 32'd0);
    check("arst_tdata", tdata, 32'd0);
    check("arst_tlast", 32'(tlast), 32'd0);
    check("arst_overflow", 32'(ovf), 32'd0);
    check("arst_dropped", 32'(dcnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_q.delete();
    drive(1, 0, 16'h0, 1, 0);
    for (int i = 1; i <= 8; i++) drive(1, 1, 16'(16'h100 + i), 1, 0);
    repeat (3) drive(1, 0, 16'h0, 1, 0);
    check("post_rst_count", log_q.size(), 32'd4);
    check_log("post_rst_w0", 0, 32'h0102_0101, 0);
    check_log("post_rst_w1", 1, 32'h0104_0103, 0);
    check_log("post_rst_w2", 2, 32'h0106_0105, 0);
    check_log("post_rst_w3", 3, 32'h0108_0107, 1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
